// File: rtl/serial_adder.sv
//============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, one bit per clock through a single
//               full adder, with a start/busy/done handshake.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_MSB_PREV = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] opa_q,     opa_d;
    logic [WIDTH-1:0] opb_q,     opb_d;
    logic [WIDTH-1:0] psum_q,    psum_d;
    logic             carry_q,   carry_d;
    logic             msb_cin_q, msb_cin_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;

    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        psum_d    = psum_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        count_d   = count_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    psum_d  = '0;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                psum_d  = {fa_s, psum_q[WIDTH-1:1]};
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = fa_c;
                // Carry out of bit WIDTH-2 is the carry into the MSB.
                if (count_q == C_MSB_PREV) begin
                    msb_cin_d = fa_c;
                end
                if (count_q == C_LAST) begin
                    state_d = S_DONE;
                    sum_d   = {fa_s, psum_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = msb_cin_q ^ fa_c;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            psum_q    <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            count_q   <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            psum_q    <= psum_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//============================================================================
// Module      : tb_serial_adder
// Description : Directed and random self-checking bench for serial_adder.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_serial_adder;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    // Called at a negedge; drives start for one edge, waits (bounded) for done,
    // returns the result seen during done and the pulse width. Ends at a negedge.
    task automatic issue_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                            output logic [W-1:0] rs, output logic rco, output logic rov,
                            output logic rbusy, output int lat, output int busy_cyc,
                            output int width);
        start = 1'b1; a = ia; b = ib; cin = icin;
        @(negedge clock);
        start = 1'b0; a = ~ia; b = ~ib; cin = ~icin;
        lat = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clock);
            lat++;
        end
        rs = sum; rco = cout; rov = overflow; rbusy = busy;
        width = 0;
        while (done === 1'b1 && width < 5) begin
            width++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got %h want 0000", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        logic [W-1:0] rs; logic rco, rov, rbusy; int lat, bc, wd;
        issue_op(16'h1234, 16'h4321, 1'b0, rs, rco, rov, rbusy, lat, bc, wd);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL basic_latency got %0d want 17", lat); end
        n_checks++; if (bc !== 16) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
        n_checks++; if (rbusy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", rbusy); end
        n_checks++; if (wd !== 1) begin n_fail++; $display("FAIL basic_done_width got %0d want 1", wd); end
        n_checks++; if (rs !== 16'h5555) begin n_fail++; $display("FAIL basic_sum got %h want 5555", rs); end
        n_checks++; if (rco !== 1'b0) begin n_fail++; $display("FAIL basic_cout got %b want 0", rco); end
        n_checks++; if (rov !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", rov); end
        repeat (3) @(negedge clock);
        n_checks++; if (sum !== 16'h5555) begin n_fail++; $display("FAIL basic_hold_sum got %h want 5555", sum); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_wrap_and_overflow;
        logic [W-1:0] rs; logic rco, rov, rbusy; int lat, bc, wd;
        issue_op(16'hFFFF, 16'h0001, 1'b0, rs, rco, rov, rbusy, lat, bc, wd);
        n_checks++; if ({rco, rs, rov} !== {1'b1, 16'h0000, 1'b0})
            begin n_fail++; $display("FAIL wrap got c=%b s=%h v=%b want c=1 s=0000 v=0", rco, rs, rov); end
        issue_op(16'h7FFF, 16'h0001, 1'b0, rs, rco, rov, rbusy, lat, bc, wd);
        n_checks++; if ({rco, rs, rov} !== {1'b0, 16'h8000, 1'b1})
            begin n_fail++; $display("FAIL sovf_pos got c=%b s=%h v=%b want c=0 s=8000 v=1", rco, rs, rov); end
        issue_op(16'h8000, 16'h8000, 1'b0, rs, rco, rov, rbusy, lat, bc, wd);
        n_checks++; if ({rco, rs, rov} !== {1'b1, 16'h0000, 1'b1})
            begin n_fail++; $display("FAIL sovf_neg got c=%b s=%h v=%b want c=1 s=0000 v=1", rco, rs, rov); end
        issue_op(16'h4000, 16'h3FFF, 1'b1, rs, rco, rov, rbusy, lat, bc, wd);
        n_checks++; if ({rco, rs, rov} !== {1'b0, 16'h8000, 1'b1})
            begin n_fail++; $display("FAIL sovf_cin got c=%b s=%h v=%b want c=0 s=8000 v=1", rco, rs, rov); end
    endtask

    task automatic test_isolation;
        logic [W-1:0] rs; logic rco, rov; int bc, dc;
        rs = 'x; rco = 1'bx; rov = 1'bx;
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; cin = 1'b1;
        @(negedge clock);
        start = 1'b0;
        bc = 0; dc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) begin dc++; rs = sum; rco = cout; rov = overflow; end
            start = (i == 4) || (done === 1'b1);
            if (i == 4) begin a = 16'hAAAA; b = 16'hAAAA; cin = 1'b0; end
            @(negedge clock);
        end
        start = 1'b0;
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL iso_done_count got %0d want 1", dc); end
        n_checks++; if (bc !== 16) begin n_fail++; $display("FAIL iso_busy_cycles got %0d want 16", bc); end
        n_checks++; if ({rco, rs, rov} !== {1'b1, 16'h0000, 1'b0})
            begin n_fail++; $display("FAIL iso_result got c=%b s=%h v=%b want c=1 s=0000 v=0", rco, rs, rov); end
    endtask

    task automatic test_reset_mid;
        int dc, bc;
        start = 1'b1; a = 16'h00FF; b = 16'h0F0F; cin = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rmid_flags got %b want 00", {busy, done}); end
        n_checks++; if ({cout, sum, overflow} !== 18'h0)
            begin n_fail++; $display("FAIL rmid_outputs got c=%b s=%h v=%b want all 0", cout, sum, overflow); end
        dc = 0; bc = 0;
        repeat (25) begin
            if (done === 1'b1) dc++;
            if (busy === 1'b1) bc++;
            @(negedge clock);
        end
        n_checks++; if ({dc, bc} !== {32'd0, 32'd0})
            begin n_fail++; $display("FAIL rmid_aborted got done=%0d busy=%0d want 0 0", dc, bc); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] rs; logic rco, rov, rbusy; int lat, bc, wd;
        issue_op(16'h0001, 16'h0002, 1'b0, rs, rco, rov, rbusy, lat, bc, wd);
        n_checks++; if (rs !== 16'h0003) begin n_fail++; $display("FAIL b2b_first_sum got %h want 0003", rs); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 17", lat); end
        issue_op(16'h1111, 16'h2222, 1'b1, rs, rco, rov, rbusy, lat, bc, wd);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 17", lat); end
        n_checks++; if (rs !== 16'h3334) begin n_fail++; $display("FAIL b2b_second_sum got %h want 3334", rs); end
    endtask

    task automatic test_random;
        logic [W-1:0] ra, rb, rs; logic rc, rco, rov, rbusy; int lat, bc, wd;
        logic [W:0] ref_full; logic ref_ovf;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            ref_ovf  = (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]);
            issue_op(ra, rb, rc, rs, rco, rov, rbusy, lat, bc, wd);
            n_checks++; if ({rco, rs} !== ref_full)
                begin n_fail++; $display("FAIL rand_sum %h+%h+%b got %h want %h", ra, rb, rc, {rco, rs}, ref_full); end
            n_checks++; if (rov !== ref_ovf)
                begin n_fail++; $display("FAIL rand_ovf %h+%h+%b got %b want %b", ra, rb, rc, rov, ref_ovf); end
            n_checks++; if (wd !== 1) begin n_fail++; $display("FAIL rand_done_width got %0d want 1", wd); end
            n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL rand_latency got %0d want 17", lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_and_overflow();
        test_isolation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
